// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a Sobel datapath: primes the line buffers, streams pixels, flushes, then signals completion.
// Define SOBEL_FRAME_TIMEOUT_EN to add a FLUSH stall watchdog that drives timeout_o; otherwise timeout_o is tied low.
//
// state   | meaning
// IDLE    | waiting for enable_i, select_o held from the previous frame
// PRIME   | Sobel modes: filling two lines plus two pixels before the window is valid
// RUN     | forwarding input pixels until a full frame has been received
// FLUSH   | draining the datapath; Sobel modes self-time px_rdy_o pulses
// DONE    | one-cycle frame_done_o, then back to IDLE
module sobel_frame_ctrl #(
  parameter int IMG_WIDTH      = 160,
  parameter int IMG_HEIGHT     = 120,
  parameter int FLUSH_GAP      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       enable_i,
  input  logic [1:0] mode_i,
  input  logic       spi_px_valid_i,
  input  logic       sobel_px_ready_i,
  output logic [1:0] select_o,
  output logic       px_rdy_o,
  output logic       start_sobel_o,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       overrun_o,
  output logic       timeout_o
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int GW    = $clog2(FLUSH_GAP);

  localparam logic [CW-1:0] TOTAL_C    = CW'(TOTAL);
  localparam logic [CW-1:0] TOTAL_LAST = CW'(TOTAL - 1);
  localparam logic [CW-1:0] PRIME_LAST = CW'(2 * IMG_WIDTH + 1);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(FLUSH_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [GW-1:0] gap_cnt;

`ifdef SOBEL_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;
`else
  wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state         <= S_IDLE;
      in_cnt        <= '0;
      out_cnt       <= '0;
      gap_cnt       <= '0;
      select_o      <= 2'b00;
      px_rdy_o      <= 1'b0;
      start_sobel_o <= 1'b0;
      busy_o        <= 1'b0;
      frame_done_o  <= 1'b0;
      overrun_o     <= 1'b0;
`ifdef SOBEL_FRAME_TIMEOUT_EN
      to_cnt        <= '0;
      timeout_o     <= 1'b0;
`endif
    end else begin
      frame_done_o <= 1'b0;
      px_rdy_o     <= 1'b0;

      if (state != S_IDLE && !enable_i) begin
        // abort: sticky flags and counters are kept for inspection until the next start
        state         <= S_IDLE;
        busy_o        <= 1'b0;
        start_sobel_o <= 1'b0;
      end else begin
        if ((state == S_PRIME || state == S_RUN || state == S_FLUSH) &&
            sobel_px_ready_i && out_cnt != TOTAL_C) begin
          out_cnt <= out_cnt + CW'(1);
        end

        case (state)
          S_IDLE: begin
            if (enable_i) begin
              select_o      <= mode_i;
              in_cnt        <= '0;
              out_cnt       <= '0;
              overrun_o     <= 1'b0;
              busy_o        <= 1'b1;
              start_sobel_o <= 1'b0;
`ifdef SOBEL_FRAME_TIMEOUT_EN
              timeout_o     <= 1'b0;
`endif
              if (mode_i[1]) state <= S_PRIME;
              else           state <= S_RUN;
            end
          end

          S_PRIME: begin
            if (spi_px_valid_i) begin
              px_rdy_o <= 1'b1;
              in_cnt   <= in_cnt + CW'(1);
              if (in_cnt == PRIME_LAST) begin
                start_sobel_o <= 1'b1;
                state         <= S_RUN;
              end
            end
          end

          S_RUN: begin
            if (spi_px_valid_i) begin
              px_rdy_o <= 1'b1;
              in_cnt   <= in_cnt + CW'(1);
              if (in_cnt == TOTAL_LAST) begin
                state   <= S_FLUSH;
                gap_cnt <= GAP_LOAD;
`ifdef SOBEL_FRAME_TIMEOUT_EN
                to_cnt  <= TO_LOAD;
`endif
              end
            end
          end

          S_FLUSH: begin
            if (spi_px_valid_i) overrun_o <= 1'b1;

            if (out_cnt == TOTAL_C) begin
              state         <= S_DONE;
              frame_done_o  <= 1'b1;
              start_sobel_o <= 1'b0;
            end
`ifdef SOBEL_FRAME_TIMEOUT_EN
            else if (to_cnt == '0) begin
              timeout_o     <= 1'b1;
              state         <= S_DONE;
              frame_done_o  <= 1'b1;
              start_sobel_o <= 1'b0;
            end
`endif
            else begin
              // no pulse on the cycle the last output arrives, so none is issued past the frame
              if (gap_cnt == '0) begin
                gap_cnt  <= GAP_LOAD;
                px_rdy_o <= select_o[1] && !(sobel_px_ready_i && out_cnt == TOTAL_LAST);
              end else begin
                gap_cnt <= gap_cnt - GW'(1);
              end
`ifdef SOBEL_FRAME_TIMEOUT_EN
              if (sobel_px_ready_i) to_cnt <= TO_LOAD;
              else                  to_cnt <= to_cnt - TW'(1);
`endif
            end
          end

          S_DONE: begin
            if (spi_px_valid_i) overrun_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end

          default: begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
